id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32 core. Sits directly downstream of register_bank.
//  Captures decoded fields plus both register read operands and presents them to EX.
//  Detects load-use hazards and inserts one bubble; honours EX back-pressure and branch flush.
//  Counts load-use bubble cycles for perf. Optionally bypasses a same-cycle WB write into operands.
// PARAMETERS
//  WIDTH      32  datapath / operand width
//  ADD_WIDTH  5   register index width
//  CTRL_W     12  opaque EX/MEM/WB control bundle width, passed through unchanged
//  CNT_W      16  bubble counter width
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous, active-high reset
//  id_valid    in   1          ID holds a valid instruction
//  id_ready    out  1          combinational; ID instruction accepted this cycle
//  id_pc       in   WIDTH      instruction PC
//  id_rs1      in   ADD_WIDTH  source 1 index (r_reg1 to register_bank)
//  id_rs2      in   ADD_WIDTH  source 2 index (r_reg2 to register_bank)
//  id_use_rs1  in   1          instruction reads rs1
//  id_use_rs2  in   1          instruction reads rs2
//  id_rd       in   ADD_WIDTH  destination index
//  id_rd1      in   WIDTH      read_data1 from register_bank
//  id_rd2      in   WIDTH      read_data2 from register_bank
//  id_imm      in   WIDTH      sign-extended immediate
//  id_ctrl     in   CTRL_W     control bundle
//  id_is_load  in   1          instruction is a load
//  id_wb_en    in   1          instruction writes rd
//  wb_en       in   1          WB write enable (same net as register_bank w_en)
//  wb_reg      in   ADD_WIDTH  WB destination (w_reg)
//  wb_data     in   WIDTH      WB data (w_data)
//  ex_flush    in   1          taken branch/jump resolved in EX
//  ex_ready    in   1          EX can accept a new instruction
//  ex_valid    out  1          EX register holds a valid instruction
//  ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_is_load, ex_wb_en
//              out  (widths as ID counterparts)  registered copies
//  bubble_cnt  out  CNT_W      load-use bubble cycles, saturating
// BEHAVIOUR
//  - Reset: ex_valid=0, every ex_* output=0, bubble_cnt=0. Reset mid-operation discards contents.
//  - advance = !ex_valid | ex_ready.
//  - load_use = ex_valid & ex_is_load & ex_rd!=0 &
//      ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - id_ready = ex_flush | (advance & !load_use).
//  - Per-edge priority: rst > ex_flush > load_use&advance > advance > hold.
//    ex_flush: ex_valid<=0; ID instruction dropped (wrong path); data outputs are don't-care.
//    load_use&advance: ex_valid<=0 (bubble), ID held, bubble_cnt+=1 (saturates at all-ones).
//    advance: all ex_* <= ID fields, ex_valid<=id_valid. Latency ID->EX exactly 1 cycle.
//    hold (ex_valid & !ex_ready, no flush): every ex_* output keeps its value.
//  - Operand capture: op = (rs==0) ? 0 : id_rdN; x0 always reads 0 regardless of inputs.
//  - ex_rd/ex_wb_en pass through unchanged; rd==0 writes are filtered downstream.
//  - ex_flush with id_valid=0 behaves identically (bubble inserted).
// CONFIGURATION
//  WB_BYPASS_EN defined: op captured = wb_data when wb_en & wb_reg!=0 & wb_reg==rsN,
//    compensating register_bank's write-at-edge/read-combinational timing; also while holding,
//    a matching WB write updates ex_op1/ex_op2 in place.
//  WB_BYPASS_EN undefined: operands come only from id_rd1/id_rd2; the hazard unit must cover WB->ID.
// TESTING
//  1. rst=1 two cycles -> ex_valid=0, ex_op1=0, bubble_cnt=0; id_ready=1.
//  2. id_valid, rs1=3 rd1=0x11, rs2=4 rd2=0x22, ex_ready=1 -> next cycle ex_op1=0x11, ex_op2=0x22, ex_valid=1.
//  3. EX holds load rd=5; ID uses rs1=5 -> id_ready=0, next ex_valid=0, bubble_cnt=1; the cycle after, ID is accepted.
//  4. ex_valid=1, ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0; ex_ready=1 -> new instruction loaded.
//  5. ex_flush=1 with id_valid=1 -> id_ready=1, next ex_valid=0; beats load_use when both are active.
//  6. WB_BYPASS_EN: wb_en=1, wb_reg=7, wb_data=0xDEAD, id_rs2=7, id_rd2=0 -> ex_op2=0xDEAD; without the macro ex_op2=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and operands, inserts load-use bubbles.
// Define WB_BYPASS_EN to forward a same-cycle WB write into the captured/held operands.
module id_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int CTRL_W    = 12,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [WIDTH-1:0]     id_pc,
  input  logic [ADD_WIDTH-1:0] id_rs1,
  input  logic [ADD_WIDTH-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [ADD_WIDTH-1:0] id_rd,
  input  logic [WIDTH-1:0]     id_rd1,
  input  logic [WIDTH-1:0]     id_rd2,
  input  logic [WIDTH-1:0]     id_imm,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 id_is_load,
  input  logic                 id_wb_en,
  input  logic                 wb_en,
  input  logic [ADD_WIDTH-1:0] wb_reg,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 ex_flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [WIDTH-1:0]     ex_pc,
  output logic [ADD_WIDTH-1:0] ex_rs1,
  output logic [ADD_WIDTH-1:0] ex_rs2,
  output logic [ADD_WIDTH-1:0] ex_rd,
  output logic [WIDTH-1:0]     ex_op1,
  output logic [WIDTH-1:0]     ex_op2,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_is_load,
  output logic                 ex_wb_en,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic             advance;
  logic             load_use;
  logic [WIDTH-1:0] op1_cap;
  logic [WIDTH-1:0] op2_cap;

  assign advance  = !ex_valid || ex_ready;
  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign id_ready = ex_flush || (advance && !load_use);

  // x0 reads as zero no matter what register_bank drives
  always_comb begin
    op1_cap = (id_rs1 == '0) ? '0 : id_rd1;
    op2_cap = (id_rs2 == '0) ? '0 : id_rd2;
`ifdef WB_BYPASS_EN
    if (wb_en && (wb_reg != '0) && (wb_reg == id_rs1)) op1_cap = wb_data;
    if (wb_en && (wb_reg != '0) && (wb_reg == id_rs2)) op2_cap = wb_data;
`endif
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_en, wb_reg, wb_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      ex_is_load <= 1'b0;
      ex_wb_en   <= 1'b0;
      bubble_cnt <= '0;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
    end else if (load_use && advance) begin
      ex_valid <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (advance) begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_rs1     <= id_rs1;
      ex_rs2     <= id_rs2;
      ex_rd      <= id_rd;
      ex_op1     <= op1_cap;
      ex_op2     <= op2_cap;
      ex_imm     <= id_imm;
      ex_ctrl    <= id_ctrl;
      ex_is_load <= id_is_load;
      ex_wb_en   <= id_wb_en;
    end
`ifdef WB_BYPASS_EN
    else begin
      // held operands would otherwise miss a write retiring while EX stalls
      if (wb_en && (wb_reg != '0) && (wb_reg == ex_rs1)) ex_op1 <= wb_data;
      if (wb_en && (wb_reg != '0) && (wb_reg == ex_rs2)) ex_op2 <= wb_data;
    end
`endif
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: accepted ID instructions are queued and checked when EX consumes them.
module tb_id_ex_stage;
  localparam int W = 32;
  localparam int A = 5;
  localparam int C = 12;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid, id_ready;
  logic [W-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [A-1:0] id_rs1, id_rs2, id_rd;
  logic         id_use_rs1, id_use_rs2, id_is_load, id_wb_en;
  logic [C-1:0] id_ctrl;
  logic         wb_en;
  logic [A-1:0] wb_reg;
  logic [W-1:0] wb_data;
  logic         ex_flush, ex_ready, ex_valid;
  logic [W-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [A-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [C-1:0] ex_ctrl;
  logic         ex_is_load, ex_wb_en;
  logic [N-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [28:0] misc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] rd1, rd2;
    logic        ld;
  } instr_t;

  exp_t sb[$];
  exp_t mon_e;
  logic acc, rdy;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(W), .ADD_WIDTH(A), .CTRL_W(C), .CNT_W(N)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_wb_en(id_wb_en), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .ex_flush(ex_flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load),
    .ex_wb_en(ex_wb_en), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic [31:0] rdv);
    if (rs == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && (wb_reg != 5'd0) && (wb_reg == rs)) return wb_data;
`endif
    return rdv;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic ld, input logic u1, input logic u2);
    instr_t i;
    i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.rd1 = rd1; i.rd2 = rd2; i.ld = ld; i.u1 = u1; i.u2 = u2;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    id_valid   = 1'b1;
    id_pc      = i.pc;
    id_rs1     = i.rs1;
    id_rs2     = i.rs2;
    id_rd      = i.rd;
    id_rd1     = i.rd1;
    id_rd2     = i.rd2;
    id_use_rs1 = i.u1;
    id_use_rs2 = i.u2;
    id_imm     = ~i.pc;
    id_ctrl    = i.pc[13:2];
    id_is_load = i.ld;
    id_wb_en   = 1'b1;
  endtask

  // one clock: sample handshake, queue the accepted instruction, advance to just past the edge
  task automatic tick(output logic a, output logic r);
    exp_t e;
    #1;
    r = id_ready;
    a = id_valid & id_ready & ~ex_flush;
    if (a) begin
      e.pc   = id_pc;
      e.op1  = exp_op(id_rs1, id_rd1);
      e.op2  = exp_op(id_rs2, id_rd2);
      e.imm  = id_imm;
      e.misc = {id_ctrl, id_rd, id_rs1, id_rs2, id_is_load, id_wb_en};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input instr_t i);
    logic a, r;
    drive(i);
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) tick(a, r);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    id_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_pc",   ex_pc,  mon_e.pc);
        chk("sb_op1",  ex_op1, mon_e.op1);
        chk("sb_op2",  ex_op2, mon_e.op2);
        chk("sb_imm",  ex_imm, mon_e.imm);
        chk("sb_misc", 32'({ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_is_load, ex_wb_en}), 32'(mon_e.misc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_ctrl = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_is_load = 1'b0; id_wb_en = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    ex_flush = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_op1", ex_op1, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_ready", 32'(id_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic capture, one-cycle latency
    send(mk(32'h100, 5'd3, 5'd4, 5'd8, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1));
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_op1", ex_op1, 32'h11);
    chk("cap_op2", ex_op2, 32'h22);

    // load-use on rs1
    send(mk(32'h104, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1));
    drive(mk(32'h108, 5'd5, 5'd6, 5'd9, 32'h55, 32'h66, 1'b0, 1'b1, 1'b1));
    tick(acc, rdy);
    chk("lu_ready", 32'(rdy), 32'd0);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(bubble_cnt), 32'd1);
    tick(acc, rdy);
    chk("lu_accept", 32'(acc), 32'd1);
    id_valid = 1'b0;

    // matching index but operand not used: no hazard
    send(mk(32'h10c, 5'd1, 5'd1, 5'd6, 32'h7, 32'h8, 1'b1, 1'b1, 1'b1));
    drive(mk(32'h110, 5'd6, 5'd6, 5'd2, 32'h9, 32'hA, 1'b0, 1'b0, 1'b0));
    tick(acc, rdy);
    chk("nouse_ready", 32'(rdy), 32'd1);
    id_valid = 1'b0;

    // load to x0 never stalls; x0 operands read zero
    send(mk(32'h114, 5'd1, 5'd2, 5'd0, 32'h3, 32'h4, 1'b1, 1'b1, 1'b1));
    drive(mk(32'h118, 5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'h1234, 1'b0, 1'b1, 1'b1));
    tick(acc, rdy);
    chk("x0_ready", 32'(rdy), 32'd1);
    chk("x0_op1", ex_op1, 32'd0);
    chk("x0_op2", ex_op2, 32'd0);
    id_valid = 1'b0;

    // EX back-pressure
    ex_ready = 1'b0;
    drive(mk(32'h200, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) begin
      tick(acc, rdy);
      chk("hold_ready", 32'(rdy), 32'd0);
      chk("hold_pc", ex_pc, 32'h118);
      chk("hold_valid", 32'(ex_valid), 32'd1);
    end
    ex_ready = 1'b1;
    tick(acc, rdy);
    chk("hold_release", 32'(acc), 32'd1);
    chk("hold_newpc", ex_pc, 32'h200);
    id_valid = 1'b0;

    // flush drops the ID instruction
    ex_flush = 1'b1;
    drive(mk(32'h204, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1));
    tick(acc, rdy);
    chk("flush_ready", 32'(rdy), 32'd1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    ex_flush = 1'b0; id_valid = 1'b0;

    // flush outranks load-use
    send(mk(32'h208, 5'd1, 5'd2, 5'd6, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1));
    drive(mk(32'h20c, 5'd6, 5'd2, 5'd7, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1));
    ex_flush = 1'b1;
    tick(acc, rdy);
    chk("flush_lu_ready", 32'(rdy), 32'd1);
    chk("flush_lu_valid", 32'(ex_valid), 32'd0);
    chk("flush_lu_cnt", 32'(bubble_cnt), 32'd1);
    ex_flush = 1'b0; id_valid = 1'b0;

    // flush with nothing in ID
    send(mk(32'h210, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1));
    ex_flush = 1'b1;
    tick(acc, rdy);
    chk("flush_idle_valid", 32'(ex_valid), 32'd0);
    ex_flush = 1'b0;

    // same-cycle WB write into ID operand
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'hDEAD;
    send(mk(32'h300, 5'd3, 5'd7, 5'd4, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1));
`ifdef WB_BYPASS_EN
    chk("byp_op2", ex_op2, 32'hDEAD);
`else
    chk("byp_op2", ex_op2, 32'h0);
`endif
    chk("byp_op1", ex_op1, 32'h5);
    wb_en = 1'b0;

    // WB write while EX holds
    send(mk(32'h304, 5'd9, 5'd10, 5'd4, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1));
    ex_ready = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'hBEEF;
    tick(acc, rdy);
    wb_en = 1'b0;
`ifdef WB_BYPASS_EN
    if (sb.size() > 0) begin
      mon_e = sb[0];
      mon_e.op1 = 32'hBEEF;
      sb[0] = mon_e;
    end
    chk("hold_byp_op1", ex_op1, 32'hBEEF);
`else
    chk("hold_byp_op1", ex_op1, 32'h1);
`endif
    chk("hold_byp_op2", ex_op2, 32'h2);
    ex_ready = 1'b1;
    tick(acc, rdy);

    // reset mid-operation discards EX contents
    send(mk(32'h308, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1));
    rst = 1'b1;
    tick(acc, rdy);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_pc", ex_pc, 32'd0);
    chk("mid_rst_cnt", 32'(bubble_cnt), 32'd0);

    // dependent load chain: one bubble per link, counter saturates
    for (int i = 0; i < 11; i++) begin
      send(mk(32'h400 + 32'(4 * i), 5'd5, 5'd0, 5'd5, 32'h40 + 32'(i), 32'h0, 1'b1, 1'b1, 1'b0));
      if (i == 3) chk("chain_cnt", 32'(bubble_cnt), 32'd3);
    end
    chk("sat_cnt", 32'(bubble_cnt), 32'd7);

    tick(acc, rdy);
    tick(acc, rdy);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
